// File: rtl/controle_preparo.sv
// controle_preparo: brew sequencer ahead of the pump controller.
// Takes a small/large request, checks water, heats with a timeout,
// fires a one-cycle pump start and waits for the end-of-pumping pulse.
// Every output is a flop loaded from the next-state decode, so outputs
// change on the same edge as the state.
// Handshake: the button and fim_bomba inputs are one-cycle pulses, sampled
// only in the states that listen for them; liga_bomba is a one-cycle pulse
// with modo already stable and held through BOMBEANDO.
module controle_preparo #(
  parameter int unsigned TIMEOUT_AQUEC = 1500000000,
  parameter int unsigned N             = 31
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       botao_pequeno,
  input  logic       botao_grande,
  input  logic       nivel_agua_ok,
  input  logic       temperatura_ok,
  input  logic       fim_bomba,
  output logic [1:0] modo,
  output logic       liga_bomba,
  output logic       aquecedor,
  output logic       pronto,
  output logic       concluido,
  output logic       erro,
  output logic [1:0] codigo_erro,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    VERIFICA  = 3'd1,
    AQUECE    = 3'd2,
    LIGA      = 3'd3,
    BOMBEANDO = 3'd4,
    FIM       = 3'd5,
    ERRO      = 3'd6
  } estado_t;

  localparam logic [1:0] MODO_NENHUM  = 2'b00;
  localparam logic [1:0] MODO_PEQUENO = 2'b01;
  localparam logic [1:0] MODO_GRANDE  = 2'b10;
  localparam logic [1:0] COD_NENHUM   = 2'b00;
  localparam logic [1:0] COD_SEM_AGUA = 2'b01;
  localparam logic [1:0] COD_TIMEOUT  = 2'b10;

  // Last timer value allowed in AQUECE before declaring a timeout.
  localparam logic [N-1:0] TIMER_ULTIMO = N'(TIMEOUT_AQUEC - 1);

  estado_t        estado_q, estado_d;
  logic [N-1:0]   timer_q, timer_d;
  logic [1:0]     modo_q, modo_d;
  logic [1:0]     codigo_q, codigo_d;
  logic           liga_q, liga_d;
  logic           aquecedor_q, aquecedor_d;
  logic           pronto_q, pronto_d;
  logic           concluido_q, concluido_d;
  logic           erro_q, erro_d;

  // Next-state, timer, latched mode/fault code and output decode.
  always_comb begin
    estado_d = estado_q;
    timer_d  = timer_q;
    modo_d   = modo_q;
    codigo_d = codigo_q;

    case (estado_q)
      OCIOSO: begin
        modo_d   = MODO_NENHUM;
        codigo_d = COD_NENHUM;
        // Small wins when both buttons pulse together.
        if (botao_pequeno) begin
          modo_d   = MODO_PEQUENO;
          estado_d = VERIFICA;
        end else if (botao_grande) begin
          modo_d   = MODO_GRANDE;
          estado_d = VERIFICA;
        end
      end
      VERIFICA: begin
        if (nivel_agua_ok) begin
          estado_d = AQUECE;
          timer_d  = '0;
        end else begin
          estado_d = ERRO;
          codigo_d = COD_SEM_AGUA;
          modo_d   = MODO_NENHUM;
        end
      end
      AQUECE: begin
        timer_d = timer_q + 1'b1;
        // Losing water outranks both temperature and timeout.
        if (!nivel_agua_ok) begin
          estado_d = ERRO;
          codigo_d = COD_SEM_AGUA;
          modo_d   = MODO_NENHUM;
        end else if (temperatura_ok) begin
          estado_d = LIGA;
        end else if (timer_q == TIMER_ULTIMO) begin
          estado_d = ERRO;
          codigo_d = COD_TIMEOUT;
          modo_d   = MODO_NENHUM;
        end
      end
      LIGA: begin
        estado_d = BOMBEANDO;
      end
      BOMBEANDO: begin
        // No abort path: the pump controller cannot be stopped mid-run.
        if (fim_bomba) begin
          estado_d = FIM;
          modo_d   = MODO_NENHUM;
        end
      end
      FIM: begin
        estado_d = OCIOSO;
        modo_d   = MODO_NENHUM;
      end
      ERRO: begin
        // The acknowledging press is consumed; it never starts a brew.
        if (botao_pequeno || botao_grande) begin
          estado_d = OCIOSO;
          codigo_d = COD_NENHUM;
        end
      end
      default: begin
        estado_d = OCIOSO;
        timer_d  = '0;
        modo_d   = MODO_NENHUM;
        codigo_d = COD_NENHUM;
      end
    endcase

    pronto_d    = (estado_d == OCIOSO);
    liga_d      = (estado_d == LIGA);
    aquecedor_d = (estado_d == AQUECE) || (estado_d == LIGA) ||
                  (estado_d == BOMBEANDO);
    concluido_d = (estado_d == FIM);
    erro_d      = (estado_d == ERRO);
  end

  // State, timer and registered outputs; reset has priority over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      timer_q     <= '0;
      modo_q      <= MODO_NENHUM;
      codigo_q    <= COD_NENHUM;
      liga_q      <= 1'b0;
      aquecedor_q <= 1'b0;
      pronto_q    <= 1'b1;
      concluido_q <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      timer_q     <= timer_d;
      modo_q      <= modo_d;
      codigo_q    <= codigo_d;
      liga_q      <= liga_d;
      aquecedor_q <= aquecedor_d;
      pronto_q    <= pronto_d;
      concluido_q <= concluido_d;
      erro_q      <= erro_d;
    end
  end

  assign modo        = modo_q;
  assign liga_bomba  = liga_q;
  assign aquecedor   = aquecedor_q;
  assign pronto      = pronto_q;
  assign concluido   = concluido_q;
  assign erro        = erro_q;
  assign codigo_erro = codigo_q;
  assign estado      = estado_q;

endmodule
